// File: rtl/i2c_pkg.sv
// Shared constants for the I2C target: FSM state codes, ACK/NACK levels, byte width.
package i2c_pkg;

  localparam int BYTE_W = 8;

  typedef logic [2:0] state_t;
  localparam state_t IDLE      = 3'd0;
  localparam state_t ADDR      = 3'd1;
  localparam state_t ACK_A     = 3'd2;
  localparam state_t PTR       = 3'd3;
  localparam state_t WRDATA    = 3'd4;
  localparam state_t READ      = 3'd5;
  localparam state_t WAIT_STOP = 3'd6;

  localparam logic ACK     = 1'b0;
  localparam logic NACK    = 1'b1;
  localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/i2c_line_cond.sv
// One open-drain line: 2-flop synchroniser, FILTER_LEN-sample glitch filter, edge pulses.
module i2c_line_cond #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0]            sync;
  logic [FILTER_LEN-1:0] hist;

  // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= 2'b11;
      hist  <= '1;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      hist  <= FILTER_LEN'({hist, sync[1]});
      rise  <= (&hist) & ~level;
      fall  <= ~(|hist) & level;
      if (&hist)       level <= 1'b1;
      else if (~|hist) level <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target bridging SDA/SCL to a 256-byte register bank via pointer/strobe interface.
// Optional bus-stuck abort enabled with `define I2C_TIMEOUT_EN.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         FILTER_LEN  = 3,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_valid,
  output logic [BYTE_W-1:0] wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  output logic [BYTE_W-1:0] rd_addr,
  input  logic [BYTE_W-1:0] rd_data,
  output logic              busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .reset_n(reset_n), .raw(scl_in),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .reset_n(reset_n), .raw(sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  state_t            state;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] ptr;
  logic [3:0]        bit_cnt;
  logic              in_ack;
  logic              to_hit;

  assign rd_addr = ptr;

`ifdef I2C_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              to_cnt <= '0;
    else if (scl_lvl || !busy) to_cnt <= '0;
    else if (!to_hit)          to_cnt <= to_cnt + TW'(1);
  end

  assign to_hit = busy && (to_cnt == TW'(TIMEOUT_CYC));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      ptr      <= '0;
      bit_cnt  <= '0;
      in_ack   <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_valid <= 1'b0;
      // Bus conditions override everything; any partial byte is dropped.
      if (stop_det || start_det) begin
        state   <= stop_det ? IDLE : ADDR;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        in_ack  <= 1'b0;
        bit_cnt <= '0;
      end else if (to_hit) begin
        state  <= WAIT_STOP;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        in_ack <= 1'b0;
      end else begin
        case (state)
          IDLE, WAIT_STOP: sda_oe <= 1'b0;

          ADDR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= {shreg[BYTE_W-2:0], sda_lvl};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              // Address 0 (general call) is never acknowledged.
              if (shreg[7:1] == DEV_ADDR && shreg[7:1] != 7'd0) begin
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                state  <= ACK_A;
              end else begin
                state  <= WAIT_STOP;
              end
            end
          end

          ACK_A: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (shreg[0] == RW_READ) begin
                shreg  <= rd_data;
                sda_oe <= ~rd_data[7];
                state  <= READ;
              end else begin
                sda_oe <= 1'b0;
                state  <= PTR;
              end
            end
          end

          PTR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= {shreg[BYTE_W-2:0], sda_lvl};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              ptr     <= shreg;
              sda_oe  <= 1'b1;
              in_ack  <= 1'b1;
              bit_cnt <= '0;
              state   <= WRDATA;
            end
          end

          WRDATA: begin
            if (scl_rise && !in_ack && bit_cnt < 4'd8) begin
              shreg   <= {shreg[BYTE_W-2:0], sda_lvl};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (in_ack) begin
                sda_oe <= 1'b0;
                in_ack <= 1'b0;
              end else if (bit_cnt == 4'd8) begin
                wr_valid <= 1'b1;
                wr_addr  <= ptr;
                wr_data  <= shreg;
                ptr      <= ptr + 8'd1;
                sda_oe   <= 1'b1;
                in_ack   <= 1'b1;
                bit_cnt  <= '0;
              end
            end
          end

          READ: begin
            // bit_cnt: bits already clocked out; 8 = master ACK slot, 9 = ACKed, reload on fall.
            if (scl_rise) begin
              if (bit_cnt < 4'd8) bit_cnt <= bit_cnt + 4'd1;
              else if (bit_cnt == 4'd8) begin
                if (sda_lvl == NACK) state <= WAIT_STOP;
                else                 bit_cnt <= 4'd9;
              end
            end else if (scl_fall) begin
              if (bit_cnt >= 4'd1 && bit_cnt < 4'd8) begin
                shreg  <= {shreg[BYTE_W-2:0], 1'b0};
                sda_oe <= ~shreg[6];
              end else if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                ptr    <= ptr + 8'd1;
              end else if (bit_cnt == 4'd9) begin
                shreg   <= rd_data;
                sda_oe  <= ~rd_data[7];
                bit_cnt <= '0;
              end
            end
          end

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
